elevator_call_scheduler: RTL and testbench

- Upstream command stage for the `elevator` car block.
- Latches floor call buttons into a pending-request vector and runs a SCAN (keep-direction) policy to decide where the car goes next.
- Drives the car's `updown` and `door_open` command inputs, and reads back the car's `floor` output as `cur_floor`.

---
 rtl/elevator_pkg.sv | 33 +++
 rtl/elevator_call_scheduler_req_scan.sv | 43 ++++
 rtl/elevator_call_scheduler.sv | 160 ++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator car and its call scheduler.
package elevator_pkg;

  localparam int FLOOR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_DWELL = 2'd3
  } sched_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [1:0] UD_HOLD = 2'b00;
  localparam logic [1:0] UD_UP   = 2'b01;
  localparam logic [1:0] UD_DOWN = 2'b10;

  // Motion command implied by a scheduler state; 2'b11 is unreachable.
  function automatic logic [1:0] updown_of(input sched_state_e s);
    logic [1:0] ud;
    case (s)
      ST_UP:   ud = UD_UP;
      ST_DOWN: ud = UD_DOWN;
      default: ud = UD_HOLD;
    endcase
    return ud;
  endfunction

endpackage

// File: rtl/elevator_call_scheduler_req_scan.sv
// Classifies outstanding requests relative to the car's current floor.
module req_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  output logic                  valid_o,
  output logic                  here_o,
  output logic                  above_o,
  output logic                  below_o
);

  localparam logic [FLOOR_W:0] NF = (FLOOR_W+1)'(NUM_FLOORS);

  logic valid_s;

  // A floor index the car reports beyond the served range yields no requests.
  always_comb begin
    valid_s = ({1'b0, cur_floor_i} < NF);
    here_o  = 1'b0;
    above_o = 1'b0;
    below_o = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (valid_s && pending_i[i]) begin
        if (FLOOR_W'(i) == cur_floor_i) begin
          here_o = 1'b1;
        end else if (FLOOR_W'(i) > cur_floor_i) begin
          above_o = 1'b1;
        end else begin
          below_o = 1'b1;
        end
      end else begin
        here_o = here_o;
      end
    end
  end

  assign valid_o = valid_s;

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches floor calls and commands car motion and doors.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = FLOOR_W_DEF,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [1:0]            updown,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [1:0]            sched_state
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);

  sched_state_e          state_q, state_d;
  dir_e                  last_dir_q, last_dir_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            updown_q, updown_d;
  logic                  door_q, door_d;

  logic                  valid_s, here_s, above_s, below_s;
  logic [NUM_FLOORS-1:0] cur_mask_s;
  logic                  cur_call_s, clr_s;

  req_scan #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan (
    .pending_i  (pending_q),
    .cur_floor_i(cur_floor),
    .valid_o    (valid_s),
    .here_o     (here_s),
    .above_o    (above_s),
    .below_o    (below_s)
  );

  // One-hot mask of the car's floor, empty when the floor is out of range.
  always_comb begin
    cur_mask_s = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (valid_s && (FLOOR_W'(i) == cur_floor)) begin
        cur_mask_s[i] = 1'b1;
      end else begin
        cur_mask_s[i] = 1'b0;
      end
    end
  end

  assign cur_call_s = |(call_btn & cur_mask_s);

  // SCAN next-state, dwell timing and request latch; clearing beats a new call.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    cnt_d      = cnt_q;
    clr_s      = 1'b0;
    if (!valid_s) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (here_s) begin
            state_d = ST_DWELL;
          end else if (above_s) begin
            state_d = ST_UP;
          end else if (below_s) begin
            state_d = ST_DOWN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_UP: begin
          if (here_s) begin
            state_d = ST_DWELL;
          end else if (above_s) begin
            state_d = ST_UP;
          end else if (below_s) begin
            state_d = ST_DOWN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DOWN: begin
          if (here_s) begin
            state_d = ST_DWELL;
          end else if (below_s) begin
            state_d = ST_DOWN;
          end else if (above_s) begin
            state_d = ST_UP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DWELL: begin
          clr_s = 1'b1;
          if (cur_call_s) begin
            cnt_d = DWELL_RELOAD;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if ((last_dir_q == DIR_UP) && above_s) begin
            state_d = ST_UP;
          end else if (below_s) begin
            state_d = ST_DOWN;
          end else if (above_s) begin
            state_d = ST_UP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if ((state_q != ST_DWELL) && (state_d == ST_DWELL)) begin
        clr_s = 1'b1;
        cnt_d = DWELL_RELOAD;
      end else begin
        cnt_d = cnt_d;
      end
    end
    if (state_d == ST_UP) begin
      last_dir_d = DIR_UP;
    end else if (state_d == ST_DOWN) begin
      last_dir_d = DIR_DOWN;
    end else begin
      last_dir_d = last_dir_d;
    end
    pending_d = (pending_q | call_btn) & ~(clr_s ? cur_mask_s : '0);
    updown_d  = updown_of(state_d);
    door_d    = (state_d == ST_DWELL);
  end

  // State, requests and Moore outputs; reset drops every request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_UP;
      pending_q  <= '0;
      cnt_q      <= '0;
      updown_q   <= UD_HOLD;
      door_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      updown_q   <= updown_d;
      door_q     <= door_d;
    end
  end

  assign updown      = updown_q;
  assign door_open   = door_q;
  assign pending     = pending_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed scoreboard bench for the elevator call scheduler (8 floors, dwell 4).
module tb_elevator_call_scheduler;
  import elevator_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] call_btn;
  logic [2:0] cur_floor;
  logic [1:0] updown;
  logic       door_open;
  logic [7:0] pending;
  logic [1:0] sched_state;

  typedef struct packed {
    logic [1:0] ud;
    logic       door;
    logic [7:0] pend;
    logic [1:0] st;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;

  elevator_call_scheduler #(.NUM_FLOORS(8), .FLOOR_W(3), .DWELL_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .call_btn   (call_btn),
    .cur_floor  (cur_floor),
    .updown     (updown),
    .door_open  (door_open),
    .pending    (pending),
    .sched_state(sched_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] ud, input logic door, input logic [7:0] pend,
                          input logic [1:0] st);
    exp_t e;
    e.ud   = ud;
    e.door = door;
    e.pend = pend;
    e.st   = st;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val("updown", 32'(updown), 32'(e.ud));
      check_val("door_open", 32'(door_open), 32'(e.door));
      check_val("pending", 32'(pending), 32'(e.pend));
      check_val("sched_state", 32'(sched_state), 32'(e.st));
      check_val("interlock", 32'((updown != 2'b00) && door_open), 32'd0);
    end
  endtask

  // Drive inputs for one cycle, expect the registered result after the edge.
  task automatic cyc(input logic [7:0] btn, input logic [2:0] fl, input logic [1:0] ud,
                     input logic door, input logic [7:0] pend, input logic [1:0] st);
    call_btn  = btn;
    cur_floor = fl;
    push_exp(ud, door, pend, st);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    logic [7:0] p;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    call_btn  = 8'h00;
    cur_floor = 3'd0;

    // Reset held, then released with no calls.
    for (int i = 0; i < 3; i++) cyc(8'h00, 3'd0, 2'b00, 1'b0, 8'h00, 2'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(8'h00, 3'd0, 2'b00, 1'b0, 8'h00, 2'd0);

    // Call at current floor.
    cyc(8'h02, 3'd1, 2'b00, 1'b0, 8'h02, 2'd0);
    for (int i = 0; i < 4; i++) cyc(8'h00, 3'd1, 2'b00, 1'b1, 8'h00, 2'd3);
    cyc(8'h00, 3'd1, 2'b00, 1'b0, 8'h00, 2'd0);

    // Single up trip 0 -> 5.
    cyc(8'h20, 3'd0, 2'b00, 1'b0, 8'h20, 2'd0);
    cyc(8'h00, 3'd0, 2'b01, 1'b0, 8'h20, 2'd1);
    for (int f = 1; f <= 4; f++) cyc(8'h00, 3'(f), 2'b01, 1'b0, 8'h20, 2'd1);
    for (int i = 0; i < 4; i++) cyc(8'h00, 3'd5, 2'b00, 1'b1, 8'h00, 2'd3);
    cyc(8'h00, 3'd5, 2'b00, 1'b0, 8'h00, 2'd0);

    // SCAN: moving up past 3 with {1,6} pending, call 4 added.
    cyc(8'h40, 3'd2, 2'b00, 1'b0, 8'h40, 2'd0);
    cyc(8'h02, 3'd2, 2'b01, 1'b0, 8'h42, 2'd1);
    cyc(8'h10, 3'd3, 2'b01, 1'b0, 8'h52, 2'd1);
    for (int i = 0; i < 4; i++) cyc(8'h00, 3'd4, 2'b00, 1'b1, 8'h42, 2'd3);
    cyc(8'h00, 3'd4, 2'b01, 1'b0, 8'h42, 2'd1);
    cyc(8'h00, 3'd5, 2'b01, 1'b0, 8'h42, 2'd1);
    for (int i = 0; i < 4; i++) cyc(8'h00, 3'd6, 2'b00, 1'b1, 8'h02, 2'd3);
    cyc(8'h00, 3'd6, 2'b10, 1'b0, 8'h02, 2'd2);
    for (int f = 5; f >= 2; f--) cyc(8'h00, 3'(f), 2'b10, 1'b0, 8'h02, 2'd2);
    for (int i = 0; i < 4; i++) cyc(8'h00, 3'd1, 2'b00, 1'b1, 8'h00, 2'd3);
    cyc(8'h00, 3'd1, 2'b00, 1'b0, 8'h00, 2'd0);

    // Dwell extension at floor 2; the re-call never reaches pending.
    cyc(8'h04, 3'd2, 2'b00, 1'b0, 8'h04, 2'd0);
    for (int i = 0; i < 3; i++) cyc(8'h00, 3'd2, 2'b00, 1'b1, 8'h00, 2'd3);
    cyc(8'h04, 3'd2, 2'b00, 1'b1, 8'h00, 2'd3);
    for (int i = 0; i < 3; i++) cyc(8'h00, 3'd2, 2'b00, 1'b1, 8'h00, 2'd3);
    cyc(8'h00, 3'd2, 2'b00, 1'b0, 8'h00, 2'd0);

    // Asynchronous reset while moving up with {6,7} pending.
    cyc(8'hC0, 3'd2, 2'b00, 1'b0, 8'hC0, 2'd0);
    cyc(8'h00, 3'd2, 2'b01, 1'b0, 8'hC0, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(2'b00, 1'b0, 8'h00, 2'd0);
    compare_out();
    #1;
    rst_n = 1'b1;
    cyc(8'h00, 3'd0, 2'b00, 1'b0, 8'h00, 2'd0);

    // All floors called from floor 0: every floor served in order, none skipped.
    cyc(8'hFF, 3'd0, 2'b00, 1'b0, 8'hFF, 2'd0);
    for (int i = 0; i < 4; i++) cyc(8'h00, 3'd0, 2'b00, 1'b1, 8'hFE, 2'd3);
    cyc(8'h00, 3'd0, 2'b01, 1'b0, 8'hFE, 2'd1);
    for (int f = 1; f <= 7; f++) begin
      p = 8'hFF << (f + 1);
      for (int i = 0; i < 4; i++) cyc(8'h00, 3'(f), 2'b00, 1'b1, p, 2'd3);
      if (f < 7) cyc(8'h00, 3'(f), 2'b01, 1'b0, p, 2'd1);
      else       cyc(8'h00, 3'(f), 2'b00, 1'b0, 8'h00, 2'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
